// File: rtl/fetch_pkg.sv
// Shared parameters and types for the instruction fetch unit.
// Holds buffer depth, datapath widths, the buffered entry layout and a
// wrap-around pointer helper used by the fetch FIFO.
package fetch_pkg;

    localparam int FETCH_DEPTH = 3;
    localparam int INSTR_W     = 16;
    localparam int PC_W        = 16;
    localparam int ROM_AW      = 15;

    // Count must represent 0..FETCH_DEPTH; pointers only 0..FETCH_DEPTH-1.
    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);
    localparam int PTR_W = $clog2(FETCH_DEPTH);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FETCH_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// FETCH_DEPTH-entry FIFO of {pc, instr} pairs for the fetch unit.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   clear       : empty the FIFO; takes priority over push and pop
//   count       : current occupancy
//   head        : entry at the head (undefined when count == 0)
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output cnt_t         count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [FETCH_DEPTH];
    ptr_t         wr_ptr_q, wr_ptr_d;
    ptr_t         rd_ptr_q, rd_ptr_d;
    cnt_t         count_q,  count_d;
    logic         do_push, do_pop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != cnt_t'(FETCH_DEPTH)) && !clear;
        do_pop   = pop  && (count_q != '0) && !clear;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues ROM reads for the upstream program counter,
// captures the synchronous ROM return one cycle later, and buffers up to
// FETCH_DEPTH {pc, instr} pairs for a valid/ready consumer.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   pc           : current program counter value
//   pc_inc       : advance the program counter (high in issue cycles)
//   rom_addr     : ROM address, pc[ROM_AW-1:0]
//   rom_data     : ROM word for the address presented in the previous cycle
//   flush        : taken jump; drops buffered and in-flight instructions
//   instr        : head instruction word (0 when empty)
//   instr_pc     : address of instr (0 when empty)
//   instr_valid  : head entry present
//   instr_ready  : consumer accepts the head entry
module instr_fetch
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_inc,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    logic            inflight_q,    inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    cnt_t            fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            issue, push, pop;
    logic [CNT_W:0]  occupancy;

    always_comb begin
        // Buffered plus in-flight entries; issuing only below FETCH_DEPTH
        // reserves a slot for every ROM return. Built from registered state
        // only, so instr_ready never reaches pc_inc combinationally.
        occupancy  = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
        // reset gates issue so pc_inc stays low while reset is asserted.
        issue      = reset && !flush && (occupancy < (CNT_W+1)'(FETCH_DEPTH));

        push       = inflight_q && !flush;
        push_entry = '{pc: inflight_pc_q, instr: rom_data};
        pop        = instr_valid && instr_ready;

        // A new issue in the same cycle as a return keeps inflight set.
        inflight_d    = issue;
        inflight_pc_d = issue ? pc : inflight_pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign pc_inc      = issue;
    assign rom_addr    = pc[ROM_AW-1:0];
    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? fifo_head.instr : '0;
    assign instr_pc    = instr_valid ? fifo_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The reference model is an ordered
// queue of outstanding fetches: every issue appends {pc, ROM[pc]} tagged with
// its issue cycle, flush or reset empties it, and an entry becomes visible
// two cycles after issue. A monitor compares the DUT head against the queue
// each cycle and retires entries on handshakes.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic               flush;
    logic               instr_ready;
    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic [ROM_AW-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .flush       (flush),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] rom_fn(input logic [ROM_AW-1:0] a);
        return 16'(a) + 16'h0100;
    endfunction

    // Synchronous ROM: word for the address presented in the previous cycle.
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, check issue at +1, let the
    // monitor run at +2, update the model at +3, then advance the pc after
    // the rising edge as the upstream program counter would.
    task automatic step(input logic rst_v, input logic flush_v, input logic rdy_v,
                        input logic [PC_W-1:0] tgt);
        logic exp_inc;
        logic inc_s;
        @(negedge clk);
        reset       = rst_v;
        flush       = flush_v;
        instr_ready = rdy_v;
        #1;
        if (!rst_v) begin
            q.delete();
            check("reset_valid",    32'(instr_valid), 32'h0);
            check("reset_instr",    32'(instr),       32'h0);
            check("reset_instr_pc", 32'(instr_pc),    32'h0);
        end
        exp_inc = rst_v && !flush_v && (q.size() < FETCH_DEPTH);
        inc_s   = pc_inc;
        check("pc_inc",   32'(pc_inc),   32'(exp_inc));
        check("rom_addr", 32'(rom_addr), 32'(pc[ROM_AW-1:0]));
        #2;
        if (flush_v) q.delete();
        if (exp_inc) q.push_back('{pc: pc, instr: rom_fn(pc[ROM_AW-1:0]), cyc: cyc});
        cyc++;
        @(posedge clk);
        #1;
        pc = !rst_v ? 16'h0 : (flush_v ? tgt : (inc_s ? pc + 16'h1 : pc));
    endtask

    // Monitor: compare the head against the model every cycle, retire on handshake.
    initial begin : monitor
        bit exp_v;
        forever begin
            @(negedge clk);
            #2;
            exp_v = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            check("instr_valid", 32'(instr_valid), 32'(exp_v));
            if (exp_v) begin
                check("instr",    32'(instr),    32'(q[0].instr));
                check("instr_pc", 32'(instr_pc), 32'(q[0].pc));
                if (instr_ready) void'(q.pop_front());
            end else begin
                check("idle_instr",    32'(instr),    32'h0);
                check("idle_instr_pc", 32'(instr_pc), 32'h0);
            end
        end
    end

    initial begin : stimulus
        reset       = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b1;
        pc          = '0;
        repeat (2) step(1'b0, 1'b0, 1'b1, 16'h0);

        // Release with ready held: first word two cycles after the first issue,
        // then one per cycle.
        repeat (8) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Consumer stalls: issue stops at three outstanding, head frozen.
        repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (6) step(1'b1, 1'b0, 1'b1, 16'h0);

        // One stalled cycle leaves two buffered and one in flight, then jump.
        step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0040);
        repeat (5) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Jump coinciding with a handshake and a ROM return.
        step(1'b1, 1'b1, 1'b1, 16'h0200);
        repeat (5) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Fill the buffer, then assert reset between clock edges.
        repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        repeat (4) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Random consumer back-pressure and jumps.
        for (int i = 0; i < 1000; i++) begin
            step(1'b1,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 16'($urandom_range(0, 16'h7fff)));
        end
        repeat (6) step(1'b1, 1'b0, 1'b1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
